// File: rtl/fp32_accum_issuer.sv
// Operand issuer for a valid-only FP32 adder: folds N_TERMS streamed terms into one sum,
// issuing (running sum, new term) pairs and capturing each adder result back into the sum.
module fp32_accum_issuer #(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic [31:0] i_term,
    input  logic        i_term_vld,
    output logic        o_term_rdy,
    output logic [31:0] o_add_a,
    output logic [31:0] o_add_b,
    output logic        o_add_vld,
    input  logic [31:0] i_add_res,
    input  logic        i_add_res_vld,
    input  logic        i_add_ovf,
    output logic [31:0] o_sum,
    output logic        o_sum_vld,
    output logic        o_sum_ovf,
    output logic        o_timeout,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS);
    localparam logic [7:0]       TMR_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tmr_q, tmr_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [31:0]        add_a_q, add_a_d;
    logic [31:0]        add_b_q, add_b_d;
    logic               add_vld_q, add_vld_d;
    logic [31:0]        sum_q, sum_d;
    logic               sum_vld_q, sum_vld_d;
    logic               sum_ovf_q, sum_ovf_d;
    logic               timeout_q, timeout_d;
    logic               term_rdy;
    logic               term_xfer;

    assign term_rdy  = ((state_q == ST_IDLE) || (state_q == ST_ACC)) && !i_clr;
    assign term_xfer = i_term_vld && term_rdy;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        ovf_acc_d = ovf_acc_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_vld_d = 1'b0;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;
        sum_vld_d = 1'b0;
        timeout_d = 1'b0;

        if (i_clr) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            tmr_d     = '0;
            ovf_acc_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (term_xfer) begin
                        acc_d     = i_term;
                        cnt_d     = CNT_W'(1);
                        ovf_acc_d = 1'b0;
                        if (N_TERMS == 1) begin
                            sum_d     = i_term;
                            sum_ovf_d = 1'b0;
                            sum_vld_d = 1'b1;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (term_xfer) begin
                        add_a_d   = acc_q;
                        add_b_d   = i_term;
                        add_vld_d = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                        tmr_d     = '0;
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // cnt already counts the term in flight, so it equals N_TERMS on the final add
                    if (i_add_res_vld) begin
                        acc_d     = i_add_res;
                        ovf_acc_d = ovf_acc_q | i_add_ovf;
                        if (cnt_q == CNT_LAST) begin
                            sum_d     = i_add_res;
                            sum_ovf_d = ovf_acc_q | i_add_ovf;
                            sum_vld_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end else begin
                        tmr_d = tmr_q + 8'd1;
                        if (tmr_q == TMR_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            ovf_acc_q <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_vld_q <= 1'b0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            sum_ovf_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            ovf_acc_q <= ovf_acc_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_vld_q <= add_vld_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            sum_ovf_q <= sum_ovf_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_term_rdy = term_rdy;
    assign o_add_a    = add_a_q;
    assign o_add_b    = add_b_q;
    assign o_add_vld  = add_vld_q;
    assign o_sum      = sum_q;
    assign o_sum_vld  = sum_vld_q;
    assign o_sum_ovf  = sum_ovf_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = (state_q == ST_ACC) || (state_q == ST_WAIT);

endmodule

// File: doc/fp32_accum_issuer.md
Name: fp32_accum_issuer

Overview:
- Operand-issuing side of the FP32 adder's valid-only interface.
- Accepts a stream of FP32 terms (for example, products from the matrix multiplier), drives adder operand pairs (running sum plus new term) with a one-cycle valid, and captures each adder result into the running sum.
- After N_TERMS terms it emits one FP32 sum with a sticky overflow flag.
- Sits between the multiplier array and the adder; one instance per output-matrix element.

Parameters:
- N_TERMS, 4: terms per sum (1..255).
- CNT_W, 8: width of the term counter.
- TIMEOUT, 8: maximum cycles waited in WAIT for the adder result before abort (2..255).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_clr  input  1  synchronous abort; discards the group in progress.
- i_term  input  32  FP32 term.
- i_term_vld  input  1  term valid.
- o_term_rdy  output  1  term ready; a transfer occurs when i_term_vld && o_term_rdy.
- o_add_a  output  32  adder operand A (running sum), registered.
- o_add_b  output  32  adder operand B (new term), registered.
- o_add_vld  output  1  adder operand valid, one-cycle pulse, registered.
- i_add_res  input  32  adder result.
- i_add_res_vld  input  1  adder result valid.
- i_add_ovf  input  1  adder overflow/special flag, qualified by i_add_res_vld.
- o_sum  output  32  completed sum.
- o_sum_vld  output  1  sum valid, one-cycle pulse.
- o_sum_ovf  output  1  OR of all i_add_ovf values in the group, valid with o_sum_vld.
- o_timeout  output  1  one-cycle pulse when a WAIT exceeds TIMEOUT.
- o_busy  output  1  high in ACC or WAIT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state <= IDLE; acc, cnt, tmr, ovf_acc <= 0.
  - All outputs 0 except o_term_rdy, which is 1 because it is decoded from IDLE.
  - Reset mid-group loses the group; no o_sum_vld is produced.
- o_term_rdy = (state==IDLE || state==ACC) && !i_clr.
- o_add_vld, o_sum_vld and o_timeout default to 0 every cycle; they are asserted only as described below.
- IDLE:
  - On transfer: acc <= i_term, cnt <= 1, ovf_acc <= 0.
  - If N_TERMS==1: o_sum <= i_term, o_sum_ovf <= 0, o_sum_vld <= 1, stay in IDLE. Otherwise go to ACC.
- ACC:
  - On transfer: o_add_a <= acc, o_add_b <= i_term, o_add_vld <= 1, cnt <= cnt+1, tmr <= 0, go to WAIT.
  - With no transfer, hold.
- WAIT:
  - If i_add_res_vld:
    - acc <= i_add_res, ovf_acc <= ovf_acc | i_add_ovf.
    - If cnt==N_TERMS: o_sum <= i_add_res, o_sum_ovf <= ovf_acc | i_add_ovf, o_sum_vld <= 1, go to IDLE.
    - Otherwise go to ACC.
  - Else: tmr <= tmr+1. When tmr==TIMEOUT-1: o_timeout <= 1, go to IDLE, group discarded.
- i_add_res_vld outside WAIT is ignored: no state change, acc untouched. The adder emits zero results with valid low; only valid-qualified results are captured.
- i_clr (synchronous, highest priority over all other transitions): go to IDLE, cnt/tmr/ovf_acc <= 0, o_add_vld <= 0, no sum pulse. o_sum keeps its last value.
- Timing with the single-cycle registered adder:
  - Each add costs 3 cycles: ACC accept, WAIT with o_add_vld high, WAIT with result valid.
  - With back-to-back terms, N_TERMS=4: first accept at edge E0, o_sum_vld high in the cycle after edge E9.
- o_sum is held between pulses; the bench samples it only while o_sum_vld is high.
- Special values such as NaN or Inf pass through unchanged via the adder result; this block performs no FP arithmetic.

Test Plan:
- N_TERMS=4, terms 3F800000, 40000000, 40400000, 40800000 back-to-back with the adder attached -> o_sum=41200000 (10.0), o_sum_vld pulses once, 10 cycles after the first accept; o_sum_ovf=0; o_term_rdy low during each WAIT.
- Same as above with i_term_vld gapped by 2 idle cycles between terms -> same o_sum=41200000; sum follows the last term by 3 cycles; o_busy high throughout the group.
- Terms 7F800000 (+Inf), 3F800000, 3F800000, 3F800000 -> o_sum=7F800000, o_sum_ovf=1.
- Adder result valid withheld, TIMEOUT=8 -> o_timeout pulses 8 cycles after o_add_vld; state returns to IDLE; no o_sum_vld; the next group of four 1.0 terms gives o_sum=40800000.
- i_clr asserted in WAIT after 2 terms, then four terms of 40000000 -> first group produces no sum; second group gives o_sum=41000000 (8.0).
- rst_n pulsed low mid-ACC -> all outputs 0 asynchronously; o_term_rdy=1 after release; a stray i_add_res_vld in IDLE leaves the next sum unaffected.
